// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and the fetch-stage state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, enable gates updates, and an
// enabled cycle with no valid input also loads a bubble while the PCs hold.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_flush,
    input  logic            i_vld,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc4,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_vld
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic            r_vld;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_vld   <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_vld   <= 1'b0;
        end else if (i_en) begin
            if (i_vld) begin
                r_instr <= i_instr;
                r_pc    <= i_pc;
                r_pc4   <= i_pc4;
                r_vld   <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_vld   <= 1'b0;
            end
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_vld   = r_vld;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding imem handshake, one-entry skid, IF/ID register.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall_F,
    input  logic            Stall_D,
    input  logic            Flush_D,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [31:0]     FetchCount,
    output logic [31:0]     BubbleCount
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pcf;
    logic            r_skid_vld;
    logic [31:0]     r_skid_dat;

    logic            w_imem_req;
    logic            w_accept;
    logic            w_rsp;
    logic            w_avail;
    logic            w_deliver;
    logic [31:0]     w_instr;
    logic [XLEN-1:0] w_pcf_plus4;

    assign w_accept    = w_imem_req & imem_ready;
    assign w_rsp       = (r_state == WAIT) & imem_rvalid;
    assign w_avail     = r_skid_vld | w_rsp;
    assign w_instr     = r_skid_vld ? r_skid_dat : imem_rdata;
    assign w_deliver   = w_avail & ~Stall_D & ~Flush_D & ~PCSrcE;
    assign w_pcf_plus4 = r_pcf + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect makes any accepted-but-unanswered request stale; DROP swallows its response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ: begin
                if (w_accept) begin
                    w_state_nxt = PCSrcE ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = REQ;
                end else if (PCSrcE) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        if (r_state == REQ) begin
            w_imem_req = ~Stall_F & ~r_skid_vld & ~rst;
        end
    end

    assign imem_req  = w_imem_req;
    assign imem_addr = r_pcf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf <= RESET_PC;
        end else if (PCSrcE) begin
            r_pcf <= PCTargetE;
        end else if (w_deliver) begin
            r_pcf <= w_pcf_plus4;
        end
    end

    // Any response that cannot be delivered this cycle is parked until decode takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_vld <= 1'b0;
            r_skid_dat <= NOP_INSTR;
        end else if (PCSrcE || w_deliver) begin
            r_skid_vld <= 1'b0;
        end else if (w_rsp) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= imem_rdata;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (~Stall_D),
        .i_flush (Flush_D | PCSrcE),
        .i_vld   (w_avail),
        .i_instr (w_instr),
        .i_pc    (r_pcf),
        .i_pc4   (w_pcf_plus4),
        .o_instr (InstrD),
        .o_pc    (PCD),
        .o_pc4   (PCPlus4D),
        .o_vld   (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    assign w_bubble = Flush_D | PCSrcE | (~Stall_D & ~w_avail);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_deliver) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign FetchCount  = r_fetch_cnt;
    assign BubbleCount = r_bubble_cnt;
`else
    assign FetchCount  = '0;
    assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of the fetch unit.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, Stall_F, Stall_D, Flush_D, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D, FetchCount, BubbleCount;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: fetch pointer, whether a request is outstanding, whether its answer is
    // stale, and at most one fetched-but-undelivered instruction.
    logic [31:0] m_pc, m_buf;
    bit          m_out, m_stale, m_have;
    logic [31:0] e_instr, e_pcd, e_pc4, e_fetch, e_bubble;
    bit          e_vld;

    // Memory: one request at a time, answered after a random number of cycles.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_pc = DEFAULT_RESET_PC; m_buf = '0;
        m_out = 0; m_stale = 0; m_have = 0;
        e_instr = NOP_INSTR; e_pcd = '0; e_pc4 = '0; e_vld = 0;
        e_fetch = '0; e_bubble = '0;
    endtask

    task automatic check_decode(input string phase);
        logic [31:0] x_fetch, x_bubble;
`ifdef FETCH_PERF_CNT_EN
        x_fetch = e_fetch; x_bubble = e_bubble;
`else
        x_fetch = '0; x_bubble = '0;
`endif
        check_eq({phase, ".InstrD"}, InstrD, e_instr);
        check_eq({phase, ".PCD"}, PCD, e_pcd);
        check_eq({phase, ".PCPlus4D"}, PCPlus4D, e_pc4);
        check_eq({phase, ".ValidD"}, 32'(ValidD), 32'(e_vld));
        check_eq({phase, ".FetchCount"}, FetchCount, x_fetch);
        check_eq({phase, ".BubbleCount"}, BubbleCount, x_bubble);
    endtask

    task automatic run_cycle(input string phase, input int p_stallf, input int p_stalld,
                             input int p_flush, input int p_redir, input int p_ready,
                             input int max_lat, input bit do_rst);
        bit exp_req, acc, resp, avail, deliver;
        logic [31:0] instr;
        @(negedge clk);
        rst       = do_rst;
        Stall_F   = ($urandom_range(99) < p_stallf);
        Stall_D   = ($urandom_range(99) < p_stalld);
        Flush_D   = ($urandom_range(99) < p_flush);
        PCSrcE    = ($urandom_range(99) < p_redir);
        PCTargetE = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
        imem_ready  = !mem_busy && ($urandom_range(99) < p_ready);
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
        if (do_rst) model_reset();
        #1;
        exp_req = !do_rst && !m_out && !m_have && !Stall_F;
        check_eq({phase, ".imem_req"}, 32'(imem_req), 32'(exp_req));
        check_eq({phase, ".imem_addr"}, imem_addr, m_pc);
        acc = exp_req && imem_ready;
        if (!do_rst) begin
            resp  = imem_rvalid && m_out && !m_stale;
            avail = m_have || resp;
            instr = m_have ? m_buf : imem_rdata;
            if (PCSrcE) begin
                if (acc) begin
                    m_out = 1; m_stale = 1;
                end else if (m_out && imem_rvalid) begin
                    m_out = 0; m_stale = 0;
                end else if (m_out) begin
                    m_stale = 1;
                end
                m_pc = PCTargetE; m_have = 0;
                e_instr = NOP_INSTR; e_vld = 0; e_bubble++;
            end else begin
                if (m_out && imem_rvalid) begin
                    m_out = 0; m_stale = 0;
                end
                if (acc) begin
                    m_out = 1; m_stale = 0;
                end
                deliver = avail && !Stall_D && !Flush_D;
                if (deliver) begin
                    e_instr = instr; e_pcd = m_pc; e_pc4 = m_pc + 32'd4; e_vld = 1;
                    m_pc = m_pc + 32'd4; m_have = 0; e_fetch++;
                end else begin
                    if (resp) begin
                        m_have = 1; m_buf = imem_rdata;
                    end
                    if (Flush_D || (!Stall_D && !avail)) begin
                        e_instr = NOP_INSTR; e_vld = 0; e_bubble++;
                    end
                end
            end
        end
        // Memory keeps answering through a reset, producing a late response to ignore.
        if (imem_rvalid) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1; mem_addr = imem_addr; mem_cnt = $urandom_range(max_lat);
        end
        @(posedge clk);
        #1;
        check_decode(phase);
    endtask

    initial begin
        rst = 1'b0; Stall_F = 0; Stall_D = 0; Flush_D = 0; PCSrcE = 0;
        PCTargetE = '0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("reset.imem_req", 32'(imem_req), 32'd0);
        check_eq("reset.imem_addr", imem_addr, DEFAULT_RESET_PC);
        check_decode("reset");
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < 30; i++) run_cycle("zero_wait", 0, 0, 0, 0, 100, 0, 0);
        for (int i = 0; i < 40; i++) run_cycle("slow_mem", 0, 0, 0, 0, 100, 3, 0);
        for (int i = 0; i < 300; i++) run_cycle("stall", 10, 40, 0, 0, 80, 3, 0);
        for (int i = 0; i < 3000; i++)
            run_cycle("random", 15, 25, 8, 6, 70, 3, ($urandom_range(149) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline: PC register, instruction-memory request/response handshake, one-entry skid buffer, and the IF/ID pipeline register.
- Consumes Stall_F, Stall_D, Flush_D from the hazard detection unit, and PCSrcE/PCTargetE from EX.
- Produces InstrD/PCD/PCPlus4D for decode; inserts bubbles while memory is slow, and drops stale responses after a redirect.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PCF value on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Stall_F  in  1  hold PCF; no new request issued.
- Stall_D  in  1  hold IF/ID contents.
- Flush_D  in  1  replace IF/ID with NOP.
- PCSrcE  in  1  redirect taken in EX.
- PCTargetE  in  XLEN  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address (= PCF).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid (≥1 cycle after accept).
- imem_rdata  in  32  response instruction.
- InstrD  out  32  decode instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).
- FetchCount  out  32  perf: instructions delivered.
- BubbleCount  out  32  perf: bubble cycles.

Behaviour:
- Reset values:
  - PCF=RESET_PC; state=REQ; skid empty.
  - InstrD=32'h0000_0013 (NOP); PCD=0; PCPlus4D=0; ValidD=0; imem_req=0 in the reset cycle; counters=0.
- One outstanding request max. PCF addresses the in-flight request and advances only on delivery. Address arithmetic wraps modulo 2^XLEN.
- FSM:
  - REQ: imem_req=~Stall_F. On imem_req&imem_ready go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, capture the instruction; go to REQ.
  - DROP: imem_req=0. On imem_rvalid, discard the data; go to REQ.
- Available instruction (avail) = WAIT&imem_rvalid, or skid full. The skid has priority; a full skid blocks new requests.
- Delivery (avail & ~Stall_D & ~Flush_D & ~PCSrcE):
  - IF/ID <= {instr, PCF, PCF+4, ValidD=1}; PCF <= PCF+4.
  - Delivered instruction is visible at decode one cycle after rvalid (or after the skid is drained).
- avail & Stall_D: a response arriving in WAIT is written to the skid. IF/ID holds; PCF holds.
- ~avail & ~Stall_D: IF/ID <= NOP, ValidD=0 (bubble); PCD/PCPlus4D hold.
- Stall_D with no avail: IF/ID holds.
- Flush_D (priority over Stall_D): IF/ID <= NOP, ValidD=0.
- PCSrcE (priority over everything except rst), same cycle:
  - PCF <= PCTargetE; skid cleared.
  - WAIT without rvalid → DROP. WAIT with rvalid → data discarded, go to REQ.
  - REQ with accept that cycle → DROP (the accepted address is stale).
  - Next request uses PCTargetE.
- PCSrcE while in DROP: stays in DROP, PCF updated.
- Stall_F in REQ suppresses imem_req. Stall_F has no effect on a response already in flight.
- rst mid-transaction: all state cleared; a late imem_rvalid after reset is ignored (state=REQ, not WAIT).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - FetchCount increments on each delivery.
  - BubbleCount increments each cycle IF/ID is loaded with a bubble or flush NOP.
  - Both wrap at 2^32.
- Undefined: both ports tied to 0 and the counter registers are not built.

Decomposition:
- riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - Fetch state enum {REQ, WAIT, DROP} (2-bit).
- Sub-module if_id_reg: IF/ID register with enable (~Stall_D), flush-to-NOP, and async reset. It is reused by the decode stage's stall logic.
- The FSM and skid buffer live in fetch_stage.

Test Plan:
- Zero-wait memory (imem_ready=1, rvalid the cycle after accept), no hazards from reset:
  - InstrD sequence at PCD 0x0, 0x4, 0x8 with ValidD=1.
  - One bubble between deliveries; PCPlus4D = PCD+4.
- Memory holds rvalid off 3 cycles:
  - 3 bubble cycles (ValidD=0, InstrD=NOP).
  - Then instruction at PCD=0x0; with FETCH_PERF_CNT_EN, BubbleCount ≥3.
- Stall_D=1 for 2 cycles while rvalid arrives with 0x00500093:
  - IF/ID holds its prior value; the response is kept in the skid.
  - After Stall_D drops, InstrD=0x00500093, PCD=0x0, and no new request issues while the skid is full.
- PCSrcE=1, PCTargetE=0x100 while in WAIT for 0x8:
  - The response for 0x8 is dropped; InstrD is NOP for the flush.
  - Next imem_addr=0x100; next valid PCD=0x100.
- Flush_D and Stall_D asserted together → IF/ID becomes NOP, ValidD=0.
- Assert rst while in WAIT, then pulse imem_rvalid after release:
  - Outputs at reset values; the response is ignored.
  - imem_addr=RESET_PC on the first request.
